// File: rtl/drac_pkg.sv
// Shared core types for the fetch / instruction cache path.
// Widths, exception causes and fetch-side bundles.
package drac_pkg;

    localparam int XLEN                 = 64;
    localparam int ADDR_SIZE            = 40;
    localparam int ICACHELINE_SIZE      = 127;
    localparam int ICACHE_IDX_BITS_SIZE = 12;
    localparam int ICACHE_VPN_BITS_SIZE = 28;
    localparam int ICACHE_LINE_TAG_W    = ADDR_SIZE - 4;

    typedef logic [ADDR_SIZE-1:0]            addr_t;
    typedef logic [XLEN-1:0]                 bus64_t;
    typedef logic [31:0]                     inst_t;
    typedef logic [ICACHELINE_SIZE:0]        icache_line_t;
    typedef logic [ICACHE_IDX_BITS_SIZE-1:0] icache_idx_t;
    typedef logic [ICACHE_VPN_BITS_SIZE-1:0] icache_vpn_t;
    typedef logic [ICACHE_LINE_TAG_W-1:0]    icache_tag_t;

    typedef logic [1:0] icache_state_t;
    localparam icache_state_t ResetState = 2'd0;
    localparam icache_state_t NoReq      = 2'd1;
    localparam icache_state_t ReqValid   = 2'd2;
    localparam icache_state_t RespReady  = 2'd3;

    localparam bus64_t INSTR_ADDR_MISALIGNED = 64'd0;
    localparam bus64_t INSTR_ACCESS_FAULT    = 64'd1;
    localparam bus64_t INSTR_PAGE_FAULT      = 64'd12;

    typedef struct packed {
        bus64_t cause;
        bus64_t origin;
        logic   valid;
    } exception_t;

    typedef struct packed {
        logic  valid;
        addr_t vaddr;
    } req_cpu_icache_t;

    typedef struct packed {
        logic       valid;
        inst_t      data;
        exception_t ex;
    } req_icache_cpu_t;

    typedef struct packed {
        logic        valid;
        icache_idx_t idx;
        icache_vpn_t vpn;
        logic        kill;
    } icache_fetch_req_t;

    typedef struct packed {
        logic         valid;
        icache_line_t data;
        logic         xcpt_pf;
        logic         xcpt_af;
    } icache_fetch_resp_t;

    // Pick one 32-bit instruction out of a 128-bit line.
    function automatic inst_t line_word(input icache_line_t line,
                                        input logic [1:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/icache_fetch_ctrl_line_buffer.sv
// One-line buffer holding the last fetched icache line.
// Looked up combinationally; filled on a clean miss response.
module icache_line_buffer
    import drac_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         fill_i,
    input  icache_tag_t  fill_tag_i,
    input  icache_line_t fill_line_i,
    input  logic         inval_i,
    input  addr_t        lookup_vaddr_i,
    output logic         hit_o,
    output inst_t        word_o
);

    logic         buf_valid_q, buf_valid_d;
    icache_tag_t  buf_tag_q, buf_tag_d;
    icache_line_t buf_line_q, buf_line_d;

    // Invalidate beats a simultaneous fill.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_line_d  = buf_line_q;
        if (fill_i) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = fill_tag_i;
            buf_line_d  = fill_line_i;
        end
        if (inval_i) begin
            buf_valid_d = 1'b0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_line_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_line_q  <= buf_line_d;
        end
    end

    assign hit_o  = buf_valid_q &&
                    (lookup_vaddr_i[ADDR_SIZE-1:4] == buf_tag_q);
    assign word_o = line_word(buf_line_q, lookup_vaddr_i[3:2]);

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Bridge between the fetch stage and the L1 instruction cache.
// Serves line-buffer hits locally and forwards misses as idx/vpn.
module icache_fetch_ctrl
    import drac_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  req_cpu_icache_t req_fetch_i,
    output logic            req_ready_o,
    input  logic            flush_i,
    input  logic            invalidate_i,
    output logic            icache_req_valid_o,
    input  logic            icache_req_ready_i,
    output icache_idx_t     icache_req_idx_o,
    output icache_vpn_t     icache_req_vpn_o,
    output logic            icache_req_kill_o,
    input  logic            icache_resp_valid_i,
    input  icache_line_t    icache_resp_data_i,
    input  logic            icache_xcpt_pf_i,
    input  logic            icache_xcpt_af_i,
    output req_icache_cpu_t resp_fetch_o
);

    icache_state_t      state_q, state_d;
    addr_t              vaddr_q, vaddr_d;
    logic               kill_q, kill_d;
    req_icache_cpu_t    resp_q, resp_d;
    icache_fetch_req_t  ireq;
    icache_fetch_resp_t iresp;
    logic               accept;
    logic               misaligned;
    logic               fill;
    logic               hit;
    inst_t              hit_word;

    assign iresp.valid   = icache_resp_valid_i;
    assign iresp.data    = icache_resp_data_i;
    assign iresp.xcpt_pf = icache_xcpt_pf_i;
    assign iresp.xcpt_af = icache_xcpt_af_i;

    assign req_ready_o = (state_q == NoReq) && !flush_i;
    assign accept      = req_fetch_i.valid && req_ready_o;
    assign misaligned  = |req_fetch_i.vaddr[1:0];

    icache_line_buffer u_buf (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fill_i         (fill),
        .fill_tag_i     (vaddr_q[ADDR_SIZE-1:4]),
        .fill_line_i    (iresp.data),
        .inval_i        (invalidate_i),
        .lookup_vaddr_i (req_fetch_i.vaddr),
        .hit_o          (hit),
        .word_o         (hit_word)
    );

    // Next-state, response and buffer-fill decisions.
    always_comb begin
        state_d      = state_q;
        vaddr_d      = vaddr_q;
        kill_d       = kill_q;
        resp_d       = resp_q;
        resp_d.valid = 1'b0;
        fill         = 1'b0;
        case (state_q)
            ResetState: begin
                state_d = NoReq;
            end
            NoReq: begin
                if (accept) begin
                    vaddr_d = req_fetch_i.vaddr;
                    if (misaligned) begin
                        resp_d.valid     = 1'b1;
                        resp_d.data      = '0;
                        resp_d.ex.valid  = 1'b1;
                        resp_d.ex.cause  = INSTR_ADDR_MISALIGNED;
                        resp_d.ex.origin = {{(XLEN-ADDR_SIZE){1'b0}},
                                            req_fetch_i.vaddr};
                    end else if (hit) begin
                        resp_d.valid = 1'b1;
                        resp_d.data  = hit_word;
                        resp_d.ex    = '0;
                    end else begin
                        state_d = ReqValid;
                    end
                end
            end
            ReqValid: begin
                if (flush_i) begin
                    state_d = NoReq;
                end else if (icache_req_ready_i) begin
                    state_d = RespReady;
                end
            end
            RespReady: begin
                if (iresp.valid) begin
                    state_d = NoReq;
                    kill_d  = 1'b0;
                    if (!kill_q && !flush_i) begin
                        resp_d.valid = 1'b1;
                        if (iresp.xcpt_pf || iresp.xcpt_af) begin
                            resp_d.data      = '0;
                            resp_d.ex.valid  = 1'b1;
                            resp_d.ex.cause  = iresp.xcpt_pf ?
                                               INSTR_PAGE_FAULT :
                                               INSTR_ACCESS_FAULT;
                            resp_d.ex.origin = {{(XLEN-ADDR_SIZE){1'b0}},
                                                vaddr_q};
                        end else begin
                            resp_d.data = line_word(iresp.data,
                                                    vaddr_q[3:2]);
                            resp_d.ex   = '0;
                            fill        = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = ResetState;
            end
        endcase
        if (flush_i) begin
            resp_d.valid = 1'b0;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ResetState;
            vaddr_q <= '0;
            kill_q  <= 1'b0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            vaddr_q <= vaddr_d;
            kill_q  <= kill_d;
            resp_q  <= resp_d;
        end
    end

    // Icache request bundle built from the latched address.
    always_comb begin
        ireq.valid = (state_q == ReqValid) && !flush_i;
        ireq.idx   = {vaddr_q[11:4], 4'b0000};
        ireq.vpn   = vaddr_q[ADDR_SIZE-1:12];
        ireq.kill  = (state_q == RespReady) && flush_i &&
                     !kill_q && !iresp.valid;
    end

    assign icache_req_valid_o = ireq.valid;
    assign icache_req_idx_o   = ireq.idx;
    assign icache_req_vpn_o   = ireq.vpn;
    assign icache_req_kill_o  = ireq.kill;
    assign resp_fetch_o       = resp_q;

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed testbench for icache_fetch_ctrl.
// Expected values are hand-computed from the line patterns used.
module tb_icache_fetch_ctrl;
    import drac_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i;
    req_cpu_icache_t req_fetch_i;
    logic            req_ready_o;
    logic            flush_i;
    logic            invalidate_i;
    logic            icache_req_valid_o;
    logic            icache_req_ready_i;
    icache_idx_t     icache_req_idx_o;
    icache_vpn_t     icache_req_vpn_o;
    logic            icache_req_kill_o;
    logic            icache_resp_valid_i;
    icache_line_t    icache_resp_data_i;
    logic            icache_xcpt_pf_i;
    logic            icache_xcpt_af_i;
    req_icache_cpu_t resp_fetch_o;

    int nvec = 0;
    int nerr = 0;
    int req_cnt = 0;
    int kill_cnt = 0;
    int r0, k0;

    localparam icache_line_t L1 =
        128'h33333333_22222222_11111111_00000000;
    localparam icache_line_t L2 =
        128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam icache_line_t L3 =
        128'h44444444_55555555_66666666_77777777;

    icache_fetch_ctrl dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .req_fetch_i         (req_fetch_i),
        .req_ready_o         (req_ready_o),
        .flush_i             (flush_i),
        .invalidate_i        (invalidate_i),
        .icache_req_valid_o  (icache_req_valid_o),
        .icache_req_ready_i  (icache_req_ready_i),
        .icache_req_idx_o    (icache_req_idx_o),
        .icache_req_vpn_o    (icache_req_vpn_o),
        .icache_req_kill_o   (icache_req_kill_o),
        .icache_resp_valid_i (icache_resp_valid_i),
        .icache_resp_data_i  (icache_resp_data_i),
        .icache_xcpt_pf_i    (icache_xcpt_pf_i),
        .icache_xcpt_af_i    (icache_xcpt_af_i),
        .resp_fetch_o        (resp_fetch_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (icache_req_valid_o) req_cnt++;
        if (icache_req_kill_o) kill_cnt++;
    end

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch(input addr_t va);
        req_fetch_i.valid = 1'b1;
        req_fetch_i.vaddr = va;
        tick();
        req_fetch_i.valid = 1'b0;
    endtask

    task automatic serve(input icache_line_t ln,
                         input logic pf, input logic af);
        icache_req_ready_i = 1'b1;
        tick();
        icache_req_ready_i  = 1'b0;
        icache_resp_valid_i = 1'b1;
        icache_resp_data_i  = ln;
        icache_xcpt_pf_i    = pf;
        icache_xcpt_af_i    = af;
        tick();
        icache_resp_valid_i = 1'b0;
        icache_xcpt_pf_i    = 1'b0;
        icache_xcpt_af_i    = 1'b0;
    endtask

    initial begin
        rst_i               = 1'b1;
        req_fetch_i         = '0;
        flush_i             = 1'b0;
        invalidate_i        = 1'b0;
        icache_req_ready_i  = 1'b0;
        icache_resp_valid_i = 1'b0;
        icache_resp_data_i  = '0;
        icache_xcpt_pf_i    = 1'b0;
        icache_xcpt_af_i    = 1'b0;
        #12;
        check("rst_ready", req_ready_o, 0);
        check("rst_resp", resp_fetch_o == '0, 1);
        check("rst_ireq", icache_req_valid_o, 0);
        check("rst_kill", icache_req_kill_o, 0);
        rst_i = 1'b0;
        tick();
        check("ready_after_rst", req_ready_o, 1);

        // miss on 0x80000000
        fetch(40'h80000000);
        check("miss_ireq", icache_req_valid_o, 1);
        check("miss_idx", icache_req_idx_o, 12'h000);
        check("miss_vpn", icache_req_vpn_o, 28'h0080000);
        check("miss_busy", req_ready_o, 0);
        tick();
        tick();
        check("ireq_held", icache_req_valid_o, 1);
        check("vpn_held", icache_req_vpn_o, 28'h0080000);
        icache_req_ready_i = 1'b1;
        tick();
        icache_req_ready_i = 1'b0;
        check("ireq_drop", icache_req_valid_o, 0);
        tick();
        tick();
        icache_resp_valid_i = 1'b1;
        icache_resp_data_i  = L1;
        tick();
        icache_resp_valid_i = 1'b0;
        check("miss_valid", resp_fetch_o.valid, 1);
        check("miss_data", resp_fetch_o.data, 32'h00000000);
        check("miss_noex", resp_fetch_o.ex.valid, 0);
        tick();
        check("pulse", resp_fetch_o.valid, 0);

        // hits out of the buffer
        r0 = req_cnt;
        fetch(40'h80000008);
        check("hit_valid", resp_fetch_o.valid, 1);
        check("hit_data", resp_fetch_o.data, 32'h22222222);
        check("hit_noireq", icache_req_valid_o, 0);
        req_fetch_i.valid = 1'b1;
        req_fetch_i.vaddr = 40'h80000004;
        tick();
        check("b2b_0", resp_fetch_o.data, 32'h11111111);
        req_fetch_i.vaddr = 40'h8000000C;
        tick();
        req_fetch_i.valid = 1'b0;
        check("b2b_1_valid", resp_fetch_o.valid, 1);
        check("b2b_1", resp_fetch_o.data, 32'h33333333);
        check("hit_nreq", req_cnt, r0);

        // misaligned
        r0 = req_cnt;
        fetch(40'h80000002);
        check("mis_valid", resp_fetch_o.valid, 1);
        check("mis_ex", resp_fetch_o.ex.valid, 1);
        check("mis_cause", resp_fetch_o.ex.cause, 0);
        check("mis_origin", resp_fetch_o.ex.origin, 64'h80000002);
        check("mis_data", resp_fetch_o.data, 0);
        tick();
        check("mis_held", resp_fetch_o.ex.origin, 64'h80000002);
        check("mis_noreq", req_cnt, r0);

        // double fault, page fault wins
        fetch(40'h1000);
        check("flt_ireq", icache_req_valid_o, 1);
        serve(L2, 1'b1, 1'b1);
        check("flt_valid", resp_fetch_o.valid, 1);
        check("flt_ex", resp_fetch_o.ex.valid, 1);
        check("flt_cause", resp_fetch_o.ex.cause, 12);
        check("flt_origin", resp_fetch_o.ex.origin, 64'h1000);
        check("flt_data", resp_fetch_o.data, 0);
        fetch(40'h1004);
        check("flt_nofill", icache_req_valid_o, 1);
        check("refetch_idx", icache_req_idx_o, 12'h000);
        check("refetch_vpn", icache_req_vpn_o, 28'h1);
        serve(L2, 1'b0, 1'b0);
        check("refetch_data", resp_fetch_o.data, 32'hBBBBBBBB);
        check("refetch_noex", resp_fetch_o.ex.valid, 0);

        // flush while waiting for the line
        k0 = kill_cnt;
        fetch(40'h3010);
        check("fl_idx", icache_req_idx_o, 12'h010);
        icache_req_ready_i = 1'b1;
        tick();
        icache_req_ready_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check("fl_kill", icache_req_kill_o, 1);
        check("fl_notready", req_ready_o, 0);
        tick();
        flush_i = 1'b0;
        #1;
        check("fl_kill_once", icache_req_kill_o, 0);
        tick();
        check("fl_wait", req_ready_o, 0);
        icache_resp_valid_i = 1'b1;
        icache_resp_data_i  = L3;
        tick();
        icache_resp_valid_i = 1'b0;
        check("fl_noresp", resp_fetch_o.valid, 0);
        check("fl_ready", req_ready_o, 1);
        check("fl_kill_cnt", kill_cnt - k0, 1);

        // fence.i drops the buffered line
        fetch(40'h2000);
        serve(L3, 1'b0, 1'b0);
        check("fi_fill", resp_fetch_o.data, 32'h77777777);
        invalidate_i = 1'b1;
        tick();
        invalidate_i = 1'b0;
        fetch(40'h2004);
        check("fi_miss", icache_req_valid_o, 1);

        // reset in the middle of that miss
        rst_i = 1'b1;
        #1;
        check("rm_ireq", icache_req_valid_o, 0);
        check("rm_ready", req_ready_o, 0);
        check("rm_resp", resp_fetch_o == '0, 1);
        check("rm_kill", icache_req_kill_o, 0);
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        check("rm_ready2", req_ready_o, 1);
        icache_resp_valid_i = 1'b1;
        icache_resp_data_i  = L1;
        tick();
        icache_resp_valid_i = 1'b0;
        check("stray_resp", resp_fetch_o.valid, 0);
        check("stray_ready", req_ready_o, 1);
        fetch(40'h2004);
        check("rm_buf_clr", icache_req_valid_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
